iomem_router: RTL and testbench
===============================

IOMEM_ROUTER -- requirements
Module: iomem_router

Interface
Parameters:
REQ-001 BASE0, 8'h03, address bits [31:24] that select slave port 0.
REQ-002 BASE1, 8'h04, address bits [31:24] that select slave port 1.
REQ-003 BASE2, 8'h05, address bits [31:24] that select slave port 2.
REQ-004 BASE3, 8'h06, address bits [31:24] that select slave port 3.
REQ-005 TIMEOUT, 8'd255, maximum number of cycles to wait for a slave ready.

Ports:
REQ-006 clk  in  1  clock; all logic is rising-edge.
REQ-007 resetn  in  1  reset, synchronous, active-low.
REQ-008 m_valid  in  1  master request; held by the master until m_ready.
REQ-009 m_wstrb  in  4  byte write strobes; 0 means read.
REQ-010 m_addr  in  32  master address.
REQ-011 m_wdata  in  32  master write data.
REQ-012 m_ready  out  1  one-cycle completion pulse to the master.
REQ-013 m_rdata  out  32  read data; valid while m_ready=1.
REQ-014 s_valid  out  4  one-hot slave request.
REQ-015 s_wstrb  out  4  registered copy of m_wstrb, shared by all slaves.
REQ-016 s_addr  out  32  registered copy of m_addr, shared by all slaves.
REQ-017 s_wdata  out  32  registered copy of m_wdata, shared by all slaves.
REQ-018 s_ready  in  4  per-slave ready.
REQ-019 s_rdata  in  128  per-slave read data; slave i uses bits [32i+31:32i].
REQ-020 err_pulse  out  1  one-cycle pulse on an unmapped access or a timeout.
REQ-021 err_addr  out  32  address of the most recent error.
REQ-022 err_count  out  8  error counter; saturates at 255.

Function
REQ-023 The FSM SHALL have four states: IDLE, ACTIVE, RESP and ERRRESP.
REQ-024 IDLE: when m_valid=1, the router SHALL latch m_addr, m_wdata and m_wstrb into s_addr, s_wdata and s_wstrb.
REQ-025 IDLE decode: the router SHALL compare m_addr[31:24] against BASE0..BASE3; if several bases match, the lowest index wins.
REQ-026 IDLE, hit on slave i: on the next cycle s_valid[i]=1, the timeout counter is cleared to 0, and the state becomes ACTIVE.
REQ-027 IDLE, no hit: the state SHALL go to ERRRESP and no s_valid bit is asserted.
REQ-028 ACTIVE: s_valid[i] SHALL stay asserted and stable, and s_addr, s_wdata and s_wstrb SHALL stay stable.
REQ-029 ACTIVE: the timeout counter SHALL increment by 1 each cycle in which s_ready[i]=0.
REQ-030 ACTIVE, s_ready[i]=1 sampled: the router SHALL capture s_rdata[i] into m_rdata, drop s_valid[i] on the next cycle, and go to RESP.
REQ-031 ACTIVE, counter equals TIMEOUT with s_ready[i]=0: the router SHALL drop s_valid[i], set m_rdata=32'hDEAD_BEEF, and go to ERRRESP.
REQ-032 s_ready[i] and the timeout condition in the same cycle SHALL be treated as success.
REQ-033 Only s_ready of the selected slave is observed; other s_ready bits and any s_ready arriving outside ACTIVE SHALL be ignored.
REQ-034 RESP: m_ready=1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-035 ERRRESP: m_ready=1 and err_pulse=1 for exactly one cycle.
REQ-036 ERRRESP: err_addr SHALL be loaded with s_addr and err_count SHALL increment, saturating at 255, then the state returns to IDLE.
REQ-037 ERRRESP from an unmapped access SHALL drive m_rdata=32'h0000_0000.
REQ-038 m_ready SHALL be 0 in IDLE, so a master that holds m_valid one extra cycle cannot start a duplicate transaction.
REQ-039 Writes SHALL be forwarded unchanged, including partial strobes; the router performs no data merging.
REQ-040 At most one transaction SHALL be outstanding at any time, and $countones(s_valid) SHALL be <= 1 in every cycle.
REQ-041 Latency for a slave that raises ready one cycle after valid SHALL be 4 cycles, from m_valid sampled in IDLE to the m_ready pulse.
REQ-042 Latency for an unmapped access SHALL be 2 cycles.

Reset
REQ-043 resetn=0 SHALL force: state=IDLE, s_valid=0, m_ready=0, err_pulse=0, err_count=0, err_addr=0, m_rdata=0, s_addr=0, s_wdata=0, s_wstrb=0, timeout counter=0.
REQ-044 Reset asserted mid-transaction SHALL abort it with no m_ready pulse, and s_valid SHALL be 0 on the cycle after reset is sampled.

Verification
REQ-045 Read at 0x0300_0000, with slave 0 returning ready one cycle after s_valid[0] and rdata 0x0000_00A5 -> s_valid=4'b0001 for 2 cycles, then m_ready pulse with m_rdata=0x0000_00A5, err_count=0.
REQ-046 Write at 0x0400_0010, wdata 0x1234_5678, wstrb 4'b0011 -> s_valid=4'b0010, s_wdata=0x1234_5678, s_wstrb=4'b0011, then a single m_ready pulse.
REQ-047 Access at 0x0700_0000 (unmapped) -> no s_valid; m_ready, err_pulse and m_rdata=0 two cycles after m_valid is sampled; err_addr=0x0700_0000; err_count=1.
REQ-048 Slave 2 never ready, TIMEOUT=8 -> s_valid[2] dropped after 8 wait cycles; m_rdata=0xDEAD_BEEF with err_pulse; a later s_ready[2] is ignored.
REQ-049 Set BASE1=BASE0=8'h03 and access 0x0300_0000 -> only s_valid[0] is asserted; separately, 260 unmapped accesses -> err_count saturates at 255.
REQ-050 Assert resetn=0 while in ACTIVE -> s_valid=0 next cycle, no m_ready; the next access after reset completes normally.

Source files
------------

// File: rtl/iomem_router.sv
// Single-master address router: decodes m_addr[31:24] onto four slave ports,
// waits for the selected slave's ready with a bounded timeout, and reports errors.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for m_valid; latches the request and decodes it
// ACTIVE  | s_valid[sel] held; waiting for s_ready[sel] or the timeout
// RESP    | one-cycle m_ready with the slave read data
// ERRRESP | one-cycle m_ready + err_pulse (unmapped address or timeout)
module iomem_router #(
    parameter logic [7:0] BASE0   = 8'h03,
    parameter logic [7:0] BASE1   = 8'h04,
    parameter logic [7:0] BASE2   = 8'h05,
    parameter logic [7:0] BASE3   = 8'h06,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         m_valid,
    input  logic [3:0]   m_wstrb,
    input  logic [31:0]  m_addr,
    input  logic [31:0]  m_wdata,
    output logic         m_ready,
    output logic [31:0]  m_rdata,
    output logic [3:0]   s_valid,
    output logic [3:0]   s_wstrb,
    output logic [31:0]  s_addr,
    output logic [31:0]  s_wdata,
    input  logic [3:0]   s_ready,
    input  logic [127:0] s_rdata,
    output logic         err_pulse,
    output logic [31:0]  err_addr,
    output logic [7:0]   err_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RESP    = 2'd2,
        ERRRESP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  sel;
    logic [1:0]  hit_idx;
    logic        hit;
    logic [7:0]  tcount;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        timeout_hit;
    logic [7:0]  page;

    assign page = m_addr[31:24];

    // Priority decode: when bases alias, the lowest port index wins.
    always_comb begin
        hit     = 1'b1;
        hit_idx = 2'd0;
        if (page == BASE0) begin
            hit_idx = 2'd0;
        end else if (page == BASE1) begin
            hit_idx = 2'd1;
        end else if (page == BASE2) begin
            hit_idx = 2'd2;
        end else if (page == BASE3) begin
            hit_idx = 2'd3;
        end else begin
            hit = 1'b0;
        end
    end

    assign sel_ready   = s_ready[sel];
    assign sel_rdata   = s_rdata[32*sel +: 32];
    assign timeout_hit = (tcount == TIMEOUT);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_ready   = 1'b0;
        err_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (m_valid) begin
                    state_nxt = hit ? ACTIVE : ERRRESP;
                end
            end
            ACTIVE: begin
                // Ready wins over a timeout landing in the same cycle.
                if (sel_ready) begin
                    state_nxt = RESP;
                end else if (timeout_hit) begin
                    state_nxt = ERRRESP;
                end
            end
            RESP: begin
                m_ready   = 1'b1;
                state_nxt = IDLE;
            end
            ERRRESP: begin
                m_ready   = 1'b1;
                err_pulse = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sel       <= 2'd0;
            s_valid   <= 4'd0;
            s_addr    <= 32'd0;
            s_wdata   <= 32'd0;
            s_wstrb   <= 4'd0;
            m_rdata   <= 32'd0;
            tcount    <= 8'd0;
            err_addr  <= 32'd0;
            err_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_valid) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_wstrb <= m_wstrb;
                        if (hit) begin
                            sel     <= hit_idx;
                            s_valid <= 4'b0001 << hit_idx;
                            tcount  <= 8'd0;
                        end else begin
                            m_rdata <= 32'h0000_0000;
                        end
                    end
                end
                ACTIVE: begin
                    if (sel_ready) begin
                        m_rdata <= sel_rdata;
                        s_valid <= 4'd0;
                    end else if (timeout_hit) begin
                        m_rdata <= 32'hDEAD_BEEF;
                        s_valid <= 4'd0;
                    end else begin
                        tcount <= tcount + 8'd1;
                    end
                end
                ERRRESP: begin
                    err_addr <= s_addr;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_router.sv
// Directed bench for iomem_router: a vector table of single transactions with a
// cycle-accurate master/slave driver, plus sequences for reset, aliasing and saturation.
module tb_iomem_router;

    localparam logic [7:0] TMO = 8'd8;

    logic         clk = 1'b0;
    logic         resetn;
    logic         m_valid;
    logic [3:0]   m_wstrb;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    logic         m_ready;
    logic [31:0]  m_rdata;
    logic [3:0]   s_valid;
    logic [3:0]   s_wstrb;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;
    logic         err_pulse;
    logic [31:0]  err_addr;
    logic [7:0]   err_count;

    logic         a_m_ready;
    logic [31:0]  a_m_rdata;
    logic [3:0]   a_s_valid;
    logic [3:0]   a_s_wstrb;
    logic [31:0]  a_s_addr;
    logic [31:0]  a_s_wdata;
    logic         a_err_pulse;
    logic [31:0]  a_err_addr;
    logic [7:0]   a_err_count;

    int n_checks = 0;
    int n_errs   = 0;
    int exp_errs = 0;
    logic [3:0] sv_seen_a;

    always #5 clk = ~clk;

    iomem_router #(.TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata), .err_pulse(err_pulse),
        .err_addr(err_addr), .err_count(err_count)
    );

    // Second instance with BASE1 aliased onto BASE0.
    iomem_router #(.BASE1(8'h03), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(a_m_ready), .m_rdata(a_m_rdata),
        .s_valid(a_s_valid), .s_wstrb(a_s_wstrb), .s_addr(a_s_addr), .s_wdata(a_s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata), .err_pulse(a_err_pulse),
        .err_addr(a_err_addr), .err_count(a_err_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          slave;       // -1: unmapped
        int          delay;       // s_valid cycles before ready; 255 = never
        logic [31:0] rdata;
        logic [3:0]  exp_sv;
        int          exp_cycles;  // cycles s_valid is high
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;     // m_valid sampled cycle counted as cycle 1
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_s_valid"}, {28'd0, s_valid}, 32'd0);
        chk({tag, "_m_ready"}, {31'd0, m_ready}, 32'd0);
        chk({tag, "_err_pulse"}, {31'd0, err_pulse}, 32'd0);
        chk({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
        chk({tag, "_err_addr"}, err_addr, 32'd0);
        chk({tag, "_m_rdata"}, m_rdata, 32'd0);
        chk({tag, "_s_addr"}, s_addr, 32'd0);
        chk({tag, "_s_wdata"}, s_wdata, 32'd0);
        chk({tag, "_s_wstrb"}, {28'd0, s_wstrb}, 32'd0);
    endtask

    task automatic run_txn(input vec_t v, input bit hold_extra);
        logic [3:0]  sv_seen;
        logic [3:0]  mask_other;
        int          sv_cycles;
        int          lat;
        bit          got;
        logic [31:0] rd_at;
        logic        ep_at;
        sv_seen   = 4'd0;
        sv_seen_a = 4'd0;
        sv_cycles = 0;
        lat       = 0;
        got       = 1'b0;
        rd_at     = 32'd0;
        ep_at     = 1'b0;
        @(negedge clk);
        m_addr  = v.addr;
        m_wdata = v.wdata;
        m_wstrb = v.wstrb;
        m_valid = 1'b1;
        s_rdata = {32'hBAD3_0003, 32'hBAD2_0002, 32'hBAD1_0001, 32'hBAD0_0000};
        if (v.slave >= 0) begin
            s_rdata[32*v.slave +: 32] = v.rdata;
            mask_other = ~(4'b0001 << v.slave);
        end else begin
            mask_other = 4'hF;
        end
        s_ready = mask_other;
        for (int c = 1; c <= 300 && !got; c++) begin
            @(negedge clk);
            sv_seen_a = sv_seen_a | a_s_valid;
            if (s_valid != 4'd0) begin
                if (sv_cycles == 0) begin
                    chk("s_addr", s_addr, v.addr);
                    chk("s_wdata", s_wdata, v.wdata);
                    chk("s_wstrb", {28'd0, s_wstrb}, {28'd0, v.wstrb});
                end
                sv_seen = sv_seen | s_valid;
                sv_cycles++;
            end
            if (m_ready) begin
                got   = 1'b1;
                lat   = c + 1;
                rd_at = m_rdata;
                ep_at = err_pulse;
            end else if (v.slave >= 0 && sv_cycles > v.delay) begin
                s_ready = mask_other | (4'b0001 << v.slave);
            end
        end
        chk("txn_done", {31'd0, got}, 32'd1);
        chk("s_valid_seen", {28'd0, sv_seen}, {28'd0, v.exp_sv});
        chk("s_valid_cycles", sv_cycles, v.exp_cycles);
        chk("m_rdata", rd_at, v.exp_rdata);
        chk("err_pulse", {31'd0, ep_at}, {31'd0, v.exp_err});
        chk("latency", lat, v.exp_lat);
        if (v.exp_err && exp_errs != 255) exp_errs++;
        if (!hold_extra) m_valid = 1'b0;
        s_ready = 4'd0;
        @(negedge clk);
        chk("m_ready_single", {31'd0, m_ready}, 32'd0);
        chk("err_pulse_single", {31'd0, err_pulse}, 32'd0);
        chk("s_valid_after", {28'd0, s_valid}, 32'd0);
        chk("err_count", {24'd0, err_count}, exp_errs);
        if (v.exp_err) chk("err_addr", err_addr, v.addr);
        if (hold_extra) begin
            m_valid = 1'b0;
            @(negedge clk);
            chk("dup_m_ready", {31'd0, m_ready}, 32'd0);
            chk("dup_s_valid", {28'd0, s_valid}, 32'd0);
        end
    endtask

    initial begin
        vec_t unm;
        vecs[0] = '{32'h0300_0000, 32'h0, 4'b0000, 0, 1, 32'h0000_00A5, 4'b0001, 2, 32'h0000_00A5, 1'b0, 4};
        vecs[1] = '{32'h0400_0010, 32'h1234_5678, 4'b0011, 1, 1, 32'h1111_2222, 4'b0010, 2, 32'h1111_2222, 1'b0, 4};
        vecs[2] = '{32'h0700_0000, 32'h0, 4'b0000, -1, 0, 32'h0, 4'b0000, 0, 32'h0, 1'b1, 2};
        vecs[3] = '{32'h06AB_CDEF, 32'h0, 4'b0000, 3, 0, 32'hCAFE_F00D, 4'b1000, 1, 32'hCAFE_F00D, 1'b0, 3};
        vecs[4] = '{32'h0500_0004, 32'hA5A5_0F0F, 4'b1111, 2, 3, 32'h55AA_55AA, 4'b0100, 4, 32'h55AA_55AA, 1'b0, 6};
        vecs[5] = '{32'h0500_0100, 32'h0, 4'b0000, 2, 255, 32'h7777_7777, 4'b0100, 9, 32'hDEAD_BEEF, 1'b1, 11};
        vecs[6] = '{32'h0000_0000, 32'h0, 4'b0000, -1, 0, 32'h0, 4'b0000, 0, 32'h0, 1'b1, 2};
        vecs[7] = '{32'h05FF_FFFC, 32'h0, 4'b0000, 2, 8, 32'h1357_9BDF, 4'b0100, 9, 32'h1357_9BDF, 1'b0, 11};
        vecs[8] = '{32'h0300_0040, 32'h89AB_CDEF, 4'b1000, 0, 2, 32'h0000_0001, 4'b0001, 3, 32'h0000_0001, 1'b0, 5};
        vecs[9] = '{32'hFF00_0000, 32'hFFFF_FFFF, 4'b0101, -1, 0, 32'h0, 4'b0000, 0, 32'h0, 1'b1, 2};
        unm = vecs[2];

        resetn  = 1'b0;
        m_valid = 1'b0;
        m_wstrb = 4'd0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        s_ready = 4'd0;
        s_rdata = 128'd0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        resetn = 1'b1;

        run_txn(vecs[0], 1'b0);
        chk("alias_s_valid", {28'd0, sv_seen_a}, 32'd1);
        for (int i = 1; i < 10; i++) run_txn(vecs[i], 1'b0);

        // Master holds m_valid through the m_ready cycle: no second transaction.
        run_txn(vecs[3], 1'b1);

        // Late ready from the timed-out slave is ignored.
        run_txn(vecs[5], 1'b0);
        s_ready = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ready_m_ready", {31'd0, m_ready}, 32'd0);
            chk("late_ready_s_valid", {28'd0, s_valid}, 32'd0);
        end
        s_ready = 4'd0;

        // Reset while ACTIVE aborts the transaction.
        @(negedge clk);
        m_addr  = 32'h0400_0020;
        m_wdata = 32'hDDDD_0001;
        m_wstrb = 4'b0001;
        m_valid = 1'b1;
        @(negedge clk);
        chk("pre_rst_s_valid", {28'd0, s_valid}, 32'h2);
        @(negedge clk);
        resetn  = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        chk_reset_state("mid_reset");
        exp_errs = 0;
        resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_m_ready", {31'd0, m_ready}, 32'd0);
        end
        run_txn(vecs[1], 1'b0);

        // Error counter saturation.
        for (int i = 0; i < 260; i++) run_txn(unm, 1'b0);
        chk("err_count_sat", {24'd0, err_count}, 32'd255);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
